// File: rtl/vga_scan_out.sv
// -----------------------------------------------------------------------------
// vga_scan_out
//
// Raster timing generator and pin driver for 640x480@60 Hz VGA (timing is
// parameterised). Publishes the current scan coordinate to the upstream colour
// path and registers the returned RGB332 value onto the pins. The value is
// blanked outside the visible area. Syncs are registered alongside the colour
// so that pins, hsync and vsync all refer to the same pixel. A one-clk
// frame_tick marks the wrap from the last pixel of a frame back to (0,0).
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   reset      in   synchronous active-high reset (priority over pix_en)
//   pix_en     in   pixel-clock enable strobe
//   rouge      in   [2:0] red from colour decoder for coordinate x/y
//   vert       in   [2:0] green from colour decoder
//   bleu       in   [1:0] blue from colour decoder
//   x          out  [9:0] horizontal counter, 0..H_TOTAL-1
//   y          out  [9:0] vertical counter, 0..V_TOTAL-1
//   visible    out  combinational, x < H_ACTIVE and y < V_ACTIVE
//   frame_tick out  one-clk pulse on the end-of-frame wrap
//   vga_r      out  [2:0] registered red pin
//   vga_g      out  [2:0] registered green pin
//   vga_b      out  [1:0] registered blue pin
//   hsync      out  registered horizontal sync, active low
//   vsync      out  registered vertical sync, active low
// -----------------------------------------------------------------------------
module vga_scan_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic [2:0] rouge,
  input  logic [2:0] vert,
  input  logic [1:0] bleu,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       visible,
  output logic       frame_tick,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b,
  output logic       hsync,
  output logic       vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Boundaries are held one bit wider than the counters so a sync pulse that
  // ends exactly at a total of 1024 does not wrap to zero.
  localparam logic [10:0] H_VIS_END = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS_END = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [2:0] r_q, r_d;
  logic [2:0] g_q, g_d;
  logic [1:0] b_q, b_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       tick_q, tick_d;

  logic       vis;
  logic       x_last;
  logic       y_last;
  logic       in_hsync;
  logic       in_vsync;

  // All decodes use the pre-increment counters, i.e. the pixel that the
  // upstream colour path is currently producing.
  assign vis      = ({1'b0, x_q} < H_VIS_END) && ({1'b0, y_q} < V_VIS_END);
  assign x_last   = (x_q == H_LAST);
  assign y_last   = (y_q == V_LAST);
  assign in_hsync = ({1'b0, x_q} >= HS_START) && ({1'b0, x_q} < HS_END);
  assign in_vsync = ({1'b0, y_q} >= VS_START) && ({1'b0, y_q} < VS_END);

  // Next-state logic for the counters and the pin registers.
  always_comb begin
    // NOTE: every output of this block gets a default first, so a path that
    // skips an assignment holds the register instead of inferring a latch.
    x_d     = x_q;
    y_d     = y_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    tick_d  = 1'b0;

    if (pix_en) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end

      r_d     = vis ? rouge : '0;
      g_d     = vis ? vert  : '0;
      b_d     = vis ? bleu  : '0;
      hsync_d = ~in_hsync;
      vsync_d = ~in_vsync;
      // Pulse only on the enabled edge that wraps the whole raster; the
      // register falls back to 0 on the following clk because pix_en is a
      // strobe (or, if tied high, the next pixel is no longer the last).
      tick_d  = x_last && y_last;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      tick_q  <= tick_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign visible    = vis;
  assign frame_tick = tick_q;
  assign vga_r      = r_q;
  assign vga_g      = g_q;
  assign vga_b      = b_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;

endmodule
